ps2_receptor_tecla: RTL

- PS/2 keyboard receiver; sits directly upstream of the key-decoding registers (alarm reset, time-set keys).
- Synchronizes and deglitches the keyboard's ps2_clk/ps2_data lines and deframes 11-bit PS/2 frames.
- Presents each valid scan code on Tecla with a one-cycle got_data strobe.
- Flags malformed or stalled frames on frame_err.

---
 rtl/ps2_receptor_tecla_if.sv | 25 ++
 rtl/ps2_receptor_tecla.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ps2_receptor_tecla_if.sv
// PS/2 receiver bus: raw keyboard lines in, scan code and strobes out.
// The receiver side takes the slave modport; the keyboard/consumer side takes master.
interface ps2_receptor_tecla_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] Tecla;
  logic       got_data;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  Tecla,
    input  got_data,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output Tecla,
    output got_data,
    output frame_err
  );
endinterface

// File: rtl/ps2_receptor_tecla.sv
// PS/2 keyboard receiver: sync, clock deglitch, 11-bit deframe, timeout.
// Define PS2_BREAK_FILTER_EN to suppress F0 break codes and the byte after.
module ps2_receptor_tecla #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic clk,
  input  logic reset,
  ps2_receptor_tecla_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_flt;
  logic          r_flt_d;
  logic [FW-1:0] r_flt_cnt;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_tecla;
  logic          r_got;
  logic          r_err;
`ifdef PS2_BREAK_FILTER_EN
  logic          r_brk;
`endif

  logic w_fall;
  logic w_data;
  logic w_tmo;
  logic w_ok;

  assign w_fall = r_flt_d & ~r_flt;
  assign w_data = r_dat_s2;
  assign w_ok   = w_data & (^{r_par, r_shift});
  assign w_tmo  = (r_state != IDLE) && !w_fall
                  && (r_to_cnt == TO_LAST);

  // Filtered clock flips only after FILTER_LEN disagreeing samples in a row
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_flt     <= 1'b1;
      r_flt_d   <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_flt_d  <= r_flt;
      if (r_clk_s2 == r_flt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_flt     <= r_clk_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
      r_tecla  <= 8'h00;
      r_got    <= 1'b0;
      r_err    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_brk    <= 1'b0;
`endif
    end else begin
      r_got <= 1'b0;
      r_err <= 1'b0;
      if (r_state == IDLE || w_fall)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_tmo) begin
        r_err    <= 1'b1;
        r_state  <= IDLE;
        r_to_cnt <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_fall && !w_data) begin
              r_state <= DATA;
              r_idx   <= '0;
            end
          end
          DATA: begin
            if (w_fall) begin
              r_shift <= {w_data, r_shift[7:1]};
              r_idx   <= r_idx + 1'b1;
              if (r_idx == 3'd7)
                r_state <= PARITY;
            end
          end
          PARITY: begin
            if (w_fall) begin
              r_par   <= w_data;
              r_state <= STOP;
            end
          end
          STOP: begin
            if (w_fall) begin
              r_state <= IDLE;
              if (w_ok) begin
`ifdef PS2_BREAK_FILTER_EN
                if (r_brk) begin
                  r_brk <= 1'b0;
                end else if (r_shift == 8'hF0) begin
                  r_brk <= 1'b1;
                end else begin
                  r_tecla <= r_shift;
                  r_got   <= 1'b1;
                end
`else
                r_tecla <= r_shift;
                r_got   <= 1'b1;
`endif
              end else begin
                r_err <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.Tecla     = r_tecla;
  assign bus.got_data  = r_got;
  assign bus.frame_err = r_err;
endmodule
